// File: rtl/audio_ctrl_if.sv
// Transport controller bus: keys, chunk selects, engine done flags and
// the command/status outputs towards the datapath engines.
interface audio_ctrl_if #(
    parameter int NUM_CHUNK = 5,
    parameter int ADDR_W    = 23,
    parameter int SPD_W     = 2
);
    logic                 i_key_rec;
    logic                 i_key_play;
    logic                 i_key_mix;
    logic                 i_key_stop;
    logic [NUM_CHUNK-1:0] i_src_sel;
    logic [NUM_CHUNK-1:0] i_dst_sel;
    logic [SPD_W-1:0]     i_speed;
    logic                 i_rec_done;
    logic                 i_play_done;
    logic                 i_mix_done;
    logic [1:0]           o_mode;
    logic                 o_busy;
    logic                 o_start;
    logic                 o_stop;
    logic [ADDR_W-1:0]    o_src_addr;
    logic [ADDR_W-1:0]    o_dst_addr;
    logic                 o_dst_en;
    logic [NUM_CHUNK-1:0] o_mix_mask;
    logic [SPD_W-1:0]     o_speed;
    logic                 o_err;

    modport slave (
        input  i_key_rec, i_key_play, i_key_mix, i_key_stop,
        input  i_src_sel, i_dst_sel, i_speed,
        input  i_rec_done, i_play_done, i_mix_done,
        output o_mode, o_busy, o_start, o_stop,
        output o_src_addr, o_dst_addr, o_dst_en,
        output o_mix_mask, o_speed, o_err
    );

    modport master (
        output i_key_rec, i_key_play, i_key_mix, i_key_stop,
        output i_src_sel, i_dst_sel, i_speed,
        output i_rec_done, i_play_done, i_mix_done,
        input  o_mode, o_busy, o_start, o_stop,
        input  o_src_addr, o_dst_addr, o_dst_en,
        input  o_mix_mask, o_speed, o_err
    );
endinterface

// File: rtl/audio_ctrl_fsm.sv
// Record/play/mix transport controller: key edges to engine start/stop
// commands, with select validation, stop timeout and busy tracking.
module audio_ctrl_fsm #(
    parameter int                NUM_CHUNK   = 5,
    parameter int                ADDR_W      = 23,
    parameter logic [ADDR_W-1:0] CHUNK_WORDS = ADDR_W'(23'h100000),
    parameter int                SPD_W       = 2,
    parameter int                TO_W        = 16
) (
    input logic         i_clk,
    input logic         i_rst,
    audio_ctrl_if.slave bus
);
    typedef enum logic [1:0] {S_IDLE, S_START, S_RUN, S_WAIT} state_t;

    localparam logic [1:0] M_REC  = 2'd1;
    localparam logic [1:0] M_PLAY = 2'd2;
    localparam logic [1:0] M_MIX  = 2'd3;

    state_t               state, state_nx;
    logic [3:0]           key, key_d, ev_q;
    logic                 armed;
    logic [TO_W-1:0]      cnt, cnt_nx;
    logic [1:0]           mode_q, mode_nx;
    logic [ADDR_W-1:0]    src_q, src_nx, dst_q, dst_nx;
    logic                 den_q, den_nx;
    logic [NUM_CHUNK-1:0] mask_q, mask_nx;
    logic [SPD_W-1:0]     spd_q, spd_nx;
    logic                 start_c, stop_c, err_c, idle_c;
    logic                 done_sel, src_one, dst_one, dst_ok, src_any;

    // Base address of the lowest selected chunk (0 when nothing is set).
    function automatic logic [ADDR_W-1:0] base(
        input logic [NUM_CHUNK-1:0] v
    );
        logic [ADDR_W-1:0] a;
        a = '0;
        for (int k = NUM_CHUNK - 1; k >= 0; k--)
            if (v[k]) a = ADDR_W'(k) * CHUNK_WORDS;
        return a;
    endfunction

    assign key = {bus.i_key_stop, bus.i_key_mix,
                  bus.i_key_play, bus.i_key_rec};

    assign src_one = $onehot(bus.i_src_sel);
    assign dst_one = $onehot(bus.i_dst_sel);
    assign src_any = |bus.i_src_sel;
    assign dst_ok  = dst_one | ~|bus.i_dst_sel;

    always_comb begin
        done_sel = 1'b0;
        unique case (mode_q)
            M_REC:   done_sel = bus.i_rec_done;
            M_PLAY:  done_sel = bus.i_play_done;
            M_MIX:   done_sel = bus.i_mix_done;
            default: done_sel = 1'b0;
        endcase
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        mode_nx  = mode_q;
        src_nx   = src_q;
        dst_nx   = dst_q;
        den_nx   = den_q;
        mask_nx  = mask_q;
        spd_nx   = spd_q;
        start_c  = 1'b0;
        stop_c   = 1'b0;
        err_c    = 1'b0;
        idle_c   = 1'b0;
        unique case (state)
            S_IDLE: begin
                // STOP outranks everything, so it also swallows other edges
                if (ev_q[3]) begin
                    state_nx = S_IDLE;
                end else if (ev_q[0]) begin
                    if (dst_one) begin
                        mode_nx  = M_REC;
                        dst_nx   = base(bus.i_dst_sel);
                        den_nx   = 1'b1;
                        state_nx = S_START;
                    end else err_c = 1'b1;
                end else if (ev_q[1]) begin
                    if (src_one && dst_ok) begin
                        mode_nx  = M_PLAY;
                        src_nx   = base(bus.i_src_sel);
                        dst_nx   = base(bus.i_dst_sel);
                        den_nx   = dst_one;
                        spd_nx   = bus.i_speed;
                        state_nx = S_START;
                    end else err_c = 1'b1;
                end else if (ev_q[2]) begin
                    if (src_any && dst_ok) begin
                        mode_nx  = M_MIX;
                        src_nx   = base(bus.i_src_sel);
                        dst_nx   = base(bus.i_dst_sel);
                        den_nx   = dst_one;
                        mask_nx  = bus.i_src_sel;
                        state_nx = S_START;
                    end else err_c = 1'b1;
                end
            end
            S_START: begin
                start_c  = 1'b1;
                state_nx = S_RUN;
            end
            S_RUN: begin
                if (done_sel) begin
                    idle_c = 1'b1;
                end else if (ev_q[3]) begin
                    stop_c   = 1'b1;
                    cnt_nx   = '0;
                    state_nx = S_WAIT;
                end
            end
            S_WAIT: begin
                if (done_sel) begin
                    idle_c = 1'b1;
                end else if (&cnt) begin
                    err_c  = 1'b1;
                    idle_c = 1'b1;
                end else begin
                    cnt_nx = cnt + TO_W'(1);
                end
            end
            default: idle_c = 1'b1;
        endcase
        if (idle_c) begin
            state_nx = S_IDLE;
            mode_nx  = '0;
            src_nx   = '0;
            dst_nx   = '0;
            den_nx   = 1'b0;
            mask_nx  = '0;
            spd_nx   = '0;
        end
    end

    // armed masks the first post-reset sample so a held key cannot fire
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state  <= S_IDLE;
            key_d  <= '0;
            ev_q   <= '0;
            armed  <= 1'b0;
            cnt    <= '0;
            mode_q <= '0;
            src_q  <= '0;
            dst_q  <= '0;
            den_q  <= 1'b0;
            mask_q <= '0;
            spd_q  <= '0;
        end else begin
            state  <= state_nx;
            key_d  <= key;
            ev_q   <= key & ~key_d & {4{armed}};
            armed  <= 1'b1;
            cnt    <= cnt_nx;
            mode_q <= mode_nx;
            src_q  <= src_nx;
            dst_q  <= dst_nx;
            den_q  <= den_nx;
            mask_q <= mask_nx;
            spd_q  <= spd_nx;
        end
    end

    assign bus.o_mode     = mode_q;
    assign bus.o_busy     = (state != S_IDLE);
    assign bus.o_start    = start_c & ~i_rst;
    assign bus.o_stop     = stop_c & ~i_rst;
    assign bus.o_err      = err_c & ~i_rst;
    assign bus.o_src_addr = src_q;
    assign bus.o_dst_addr = dst_q;
    assign bus.o_dst_en   = den_q;
    assign bus.o_mix_mask = mask_q;
    assign bus.o_speed    = spd_q;
endmodule
